// File: rtl/uart_rx_oversample_if.sv
// Receiver-side signal bundle: baud enable and serial line in, received byte and flags out.
// The master modport is the receiver, and the slave modport is whatever feeds and consumes it.
interface uart_rx_oversample_if #(
  parameter int DATA_BITS = 8
);
  logic                 baud_tick;
  logic                 UART_RX;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_end;
  logic                 rx_status;
  logic                 frame_err;

  modport master (
    input  baud_tick, UART_RX,
    output rx_data, rx_end, rx_status, frame_err
  );

  modport slave (
    output baud_tick, UART_RX,
    input  rx_data, rx_end, rx_status, frame_err
  );
endinterface

// File: rtl/uart_rx_oversample.sv
// 8N1 UART receiver that uses an OVERSAMPLE x baud tick enable and takes each bit at its midpoint.
// Good bytes are delivered with a one-clk rx_end pulse. A low stop bit gives a one-clk frame_err pulse instead.
module uart_rx_oversample #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  uart_rx_oversample_if.master  bus
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] MID_CNT  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_CNT = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t               state, state_nxt;
  logic                 sync_p0, sync_p1;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_end_q, frame_err_q;
  logic                 counting, sample_en, stop_ok, stop_bad, rx_status_c;
  logic                 line;

  // Two-flop synchronizer stage. It resets to 1 so that it looks like an idle line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= bus.UART_RX;
      sync_p1 <= sync_p0;
    end
  end

  assign line = sync_p1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.baud_tick) begin
      case (state)
        IDLE:  if (!line) state_nxt = START;
        START: if (tick_cnt == MID_CNT) state_nxt = line ? IDLE : DATA;
        DATA:  if (tick_cnt == FULL_CNT && bit_cnt == LAST_BIT) state_nxt = STOP;
        STOP:  if (tick_cnt == FULL_CNT) state_nxt = line ? IDLE : BREAK;
        BREAK: if (line) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    counting    = 1'b0;
    sample_en   = 1'b0;
    stop_ok     = 1'b0;
    stop_bad    = 1'b0;
    rx_status_c = (state != IDLE);
    case (state)
      START: counting = 1'b1;
      DATA: begin
        counting  = 1'b1;
        sample_en = bus.baud_tick && (tick_cnt == FULL_CNT);
      end
      STOP: begin
        counting = 1'b1;
        stop_ok  = bus.baud_tick && (tick_cnt == FULL_CNT) && line;
        stop_bad = bus.baud_tick && (tick_cnt == FULL_CNT) && !line;
      end
      default: ;
    endcase
  end

  // Counters clear on every state change. IDLE and BREAK hold them at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
    end else if (state_nxt != state) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
    end else if (bus.baud_tick && counting) begin
      if (sample_en) begin
        tick_cnt <= '0;
        bit_cnt  <= bit_cnt + 1'b1;
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg       <= '0;
      rx_data_q   <= '0;
      rx_end_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (sample_en) shreg[bit_cnt] <= line;
      if (stop_ok)   rx_data_q      <= shreg;
      rx_end_q    <= stop_ok;
      frame_err_q <= stop_bad;
    end
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_end    = rx_end_q;
  assign bus.frame_err = frame_err_q;
  assign bus.rx_status = rx_status_c;

endmodule
